assoc_way_array: RTL and testbench
==================================

ASSOC_WAY_ARRAY -- requirements
Module: assoc_way_array

Interface
REQ-001 SHALL have parameter WAYS, default 2, number of ways (2..8).
REQ-002 SHALL have parameter SETS, default 64, sets per way.
REQ-003 SHALL have parameter WORDS, default 8, words per line.
REQ-004 SHALL have parameter DATA_W, default 16, word width.
REQ-005 SHALL have parameter TAG_W, default 7, tag width; per-way metadata is {valid, tag}, TAG_W+1 bits.
REQ-006 SHALL have ports:
  clk  in  1  clock; reset rst, synchronous, active-high; clock clk
  rst  in  1  synchronous active-high reset
  set_enable  in  SETS  one-hot set select
  word_enable  in  WORDS  one-hot word select
  tag_in  in  TAG_W  lookup tag
  rd_en  in  1  read access strobe (LRU update only)
  wr_en  in  1  write data_in to hit way
  data_in  in  DATA_W  write data
  hit  out  1  lookup hit
  hit_way  out  WAYS  one-hot hitting way
  data_out  out  DATA_W  hit-way word
  fill_start  in  1  begin line fill for set_enable/tag_in
  fill_valid  in  1  fill beat valid
  fill_data  in  DATA_W  fill beat data
  fill_ready  out  1  high while in FILL
  busy  out  1  high while not IDLE
  fill_done  out  1  one-cycle pulse on COMMIT

Function
REQ-007 SHALL decode set/word as lowest set bit of set_enable/word_enable; all-zero set_enable forces hit=0, data_out=0, no writes or fills.
REQ-008 SHALL compute hit_way[w] = valid[w][set] & (tag[w][set]==tag_in), hit = |hit_way, combinationally.
REQ-009 SHALL drive data_out combinationally from hit way at selected word; 0 on miss.
REQ-010 SHALL, in IDLE with wr_en & hit, write data_in at next posedge; wr_en on miss, or outside IDLE, SHALL be ignored.
REQ-011 SHALL mark hit way MRU at posedge when (rd_en|wr_en) & hit in IDLE.
REQ-012 SHALL have states IDLE, FILL, COMMIT; IDLE->FILL on fill_start; FILL->COMMIT on final (WORDS-th) accepted beat; COMMIT->IDLE unconditionally next cycle.
REQ-013 SHALL, on fill_start accept, latch set, tag, victim (lowest-index invalid way, else policy of REQ-023/024), clear victim valid, zero beat counter.
REQ-014 SHALL, in FILL, write fill_data to victim word[counter] on each fill_valid and increment counter; cycles without fill_valid hold counter.
REQ-015 SHALL, in COMMIT, set victim valid=1, tag=latched tag, mark victim MRU, pulse fill_done for exactly one cycle.
REQ-016 SHALL ignore fill_start while busy; lookups to other lines remain served during FILL/COMMIT.
REQ-017 SHALL keep fill_ready=1 only in FILL, busy=1 in FILL and COMMIT.

Reset
REQ-018 SHALL on rst clear all valid bits, tags, data words to 0 and LRU state to way-index order (way 0 LRU).
REQ-019 SHALL on rst force IDLE, counter 0; outputs hit=0, hit_way=0, data_out=0, fill_ready=0, busy=0, fill_done=0.
REQ-020 SHALL abort any fill in progress on rst with no partial commit.
REQ-021 SHALL give rst priority over all other inputs in the same cycle.

Configuration
REQ-022 SHALL select replacement via macro ASSOC_WAY_ARRAY_LRU_EN.
REQ-023 SHALL, with ASSOC_WAY_ARRAY_LRU_EN defined, keep true per-set LRU order; victim = least-recently used way.
REQ-024 SHALL, without it, use one global round-robin pointer (reset 0, +1 mod WAYS per COMMIT) as victim; rd_en/wr_en do not affect it.

Verification
REQ-025 After reset, set 5 tag 0x12 rd_en -> hit=0, hit_way=0, data_out=0x0000.
REQ-026 fill_start set 5 tag 0x12, beats 0x1000..0x1007 -> fill_done one cycle after 8th beat; then word 3 lookup -> hit=1, hit_way=2'b01, data_out=0x1003.
REQ-027 Fill set 5 tag 0x13 (->way1), rd_en tag 0x12, fill tag 0x14 -> with macro evicts way1; without macro evicts way0 (pointer=0).
REQ-028 wr_en set 5 tag 0x12 word 7 data 0xBEEF -> next cycle data_out=0xBEEF; wr_en tag 0x7F -> no array change.
REQ-029 rst after 3 fill beats -> next cycle busy=0, fill_ready=0, set 5 all ways miss.
REQ-030 fill_start during FILL and fill_valid gaps of 2 cycles -> ignored start, counter held, commit after exactly 8 beats.

Source files
------------

// File: rtl/assoc_way_array.sv
// assoc_way_array: set-associative tag/data array with a line-fill controller.
// Lookups (hit, hit_way, data_out) are combinational on set_enable, word_enable
// and tag_in. A line fill runs IDLE -> FILL -> COMMIT and keeps the victim way
// invalid until COMMIT, so a partly filled line never hits.
// Build option: define ASSOC_WAY_ARRAY_LRU_EN for true per-set LRU replacement.
// Without it, one global round-robin pointer selects the victim.
module assoc_way_array #(
    parameter int WAYS   = 2,
    parameter int SETS   = 64,
    parameter int WORDS  = 8,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SETS-1:0]   set_enable,
    input  logic [WORDS-1:0]  word_enable,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    output logic              hit,
    output logic [WAYS-1:0]   hit_way,
    output logic [DATA_W-1:0] data_out,
    input  logic              fill_start,
    input  logic              fill_valid,
    input  logic [DATA_W-1:0] fill_data,
    output logic              fill_ready,
    output logic              busy,
    output logic              fill_done
);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int SET_W  = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNT_W  = $clog2(WORDS + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FILL   = 2'b01,
        ST_COMMIT = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [SET_W-1:0]  fill_set_r;
    logic [TAG_W-1:0]  fill_tag_r;
    logic [WAY_W-1:0]  victim_r;

    logic              valid_r [WAYS][SETS];
    logic [TAG_W-1:0]  tag_r   [WAYS][SETS];
    logic [DATA_W-1:0] data_r  [WAYS][SETS][WORDS];

    logic [SET_W-1:0]  set_idx_s;
    logic              set_any_s;
    logic [WORD_W-1:0] word_idx_s;
    logic [WAY_W-1:0]  hit_idx_s;
    logic              inv_found_s;
    logic [WAY_W-1:0]  inv_way_s;
    logic [WAY_W-1:0]  policy_way_s;
    logic [WAY_W-1:0]  victim_s;
    logic              fill_accept_s;
    logic              beat_s;
    logic              last_beat_s;
    logic              wr_hit_s;

    // Resolve the set and word selects to the index of their lowest set bit.
    always_comb begin
        set_idx_s  = '0;
        word_idx_s = '0;
        for (int i = SETS - 1; i >= 0; i--) begin
            set_idx_s = set_enable[i] ? SET_W'(i) : set_idx_s;
        end
        for (int i = WORDS - 1; i >= 0; i--) begin
            word_idx_s = word_enable[i] ? WORD_W'(i) : word_idx_s;
        end
        set_any_s = |set_enable;
    end

    // Tag compare in every way of the selected set; the word comes from the lowest hitting way.
    always_comb begin
        hit_way   = '0;
        hit_idx_s = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_way[w] = set_any_s & valid_r[w][set_idx_s] & (tag_r[w][set_idx_s] == tag_in);
            hit_idx_s  = hit_way[w] ? WAY_W'(w) : hit_idx_s;
        end
        hit = |hit_way;
        if (hit) begin
            data_out = data_r[hit_idx_s][set_idx_s][word_idx_s];
        end else begin
            data_out = '0;
        end
    end

    // A free way is always preferred; the replacement policy only chooses among a full set.
    always_comb begin
        inv_found_s = 1'b0;
        inv_way_s   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            inv_way_s   = valid_r[w][set_idx_s] ? inv_way_s : WAY_W'(w);
            inv_found_s = inv_found_s | ~valid_r[w][set_idx_s];
        end
        victim_s = inv_found_s ? inv_way_s : policy_way_s;
    end

    assign fill_accept_s = (state_r == ST_IDLE) & fill_start & set_any_s;
    assign beat_s        = (state_r == ST_FILL) & fill_valid;
    assign last_beat_s   = beat_s & (cnt_r == CNT_W'(WORDS - 1));
    assign wr_hit_s      = (state_r == ST_IDLE) & wr_en & hit;

`ifdef ASSOC_WAY_ARRAY_LRU_EN
    // rank 0 is the most recently used way and rank WAYS-1 the least recently used.
    logic [WAY_W-1:0] rank_r [SETS][WAYS];
    logic             touch_en_s;
    logic [SET_W-1:0] touch_set_s;
    logic [WAY_W-1:0] touch_way_s;

    // The least recently used way of the selected set is the policy victim.
    always_comb begin
        policy_way_s = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            policy_way_s = (rank_r[set_idx_s][w] == WAY_W'(WAYS - 1)) ? WAY_W'(w) : policy_way_s;
        end
    end

    // A committed fill or a hitting access in IDLE marks one way most recently used.
    always_comb begin
        touch_en_s  = 1'b0;
        touch_set_s = set_idx_s;
        touch_way_s = hit_idx_s;
        if (state_r == ST_COMMIT) begin
            touch_en_s  = 1'b1;
            touch_set_s = fill_set_r;
            touch_way_s = victim_r;
        end else if ((state_r == ST_IDLE) & (rd_en | wr_en) & hit) begin
            touch_en_s = 1'b1;
        end else begin
            touch_en_s = 1'b0;
        end
    end

    // Move the touched way to rank 0 and age every way that was more recent than it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    rank_r[s][w] <= WAY_W'(WAYS - 1 - w);
                end
            end
        end else if (touch_en_s) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == touch_way_s) begin
                    rank_r[touch_set_s][w] <= '0;
                end else if (rank_r[touch_set_s][w] < rank_r[touch_set_s][touch_way_s]) begin
                    rank_r[touch_set_s][w] <= rank_r[touch_set_s][w] + WAY_W'(1);
                end else begin
                    rank_r[touch_set_s][w] <= rank_r[touch_set_s][w];
                end
            end
        end
    end
`else
    logic [WAY_W-1:0] rr_ptr_r;
    logic             rd_unused_s;

    // rd_en only matters for LRU ordering, which round-robin replacement does not keep.
    assign rd_unused_s  = rd_en;
    assign policy_way_s = rr_ptr_r;

    // Global round-robin pointer advances once per committed line.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if (state_r == ST_COMMIT) begin
            rr_ptr_r <= (rr_ptr_r == WAY_W'(WAYS - 1)) ? '0 : rr_ptr_r + WAY_W'(1);
        end
    end
`endif

    // Next-state logic and status outputs of the fill controller.
    always_comb begin
        state_s    = state_r;
        fill_ready = 1'b0;
        busy       = 1'b0;
        fill_done  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fill_accept_s) begin
                    state_s = ST_FILL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                fill_ready = 1'b1;
                busy       = 1'b1;
                if (last_beat_s) begin
                    state_s = ST_COMMIT;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_COMMIT: begin
                busy      = 1'b1;
                fill_done = 1'b1;
                state_s   = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Fill controller state, beat counter and the set/tag/victim latched on fill start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            fill_set_r <= '0;
            fill_tag_r <= '0;
            victim_r   <= '0;
        end else begin
            state_r <= state_s;
            if (fill_accept_s) begin
                fill_set_r <= set_idx_s;
                fill_tag_r <= tag_in;
                victim_r   <= victim_s;
                cnt_r      <= '0;
            end else if (beat_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Array update: hit writes, fill beats, victim invalidation on start, validation on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_r[w][s] <= 1'b0;
                    tag_r[w][s]   <= '0;
                    for (int d = 0; d < WORDS; d++) begin
                        data_r[w][s][d] <= '0;
                    end
                end
            end
        end else begin
            if (wr_hit_s) begin
                data_r[hit_idx_s][set_idx_s][word_idx_s] <= data_in;
            end
            if (beat_s) begin
                data_r[victim_r][fill_set_r][cnt_r[WORD_W-1:0]] <= fill_data;
            end
            if (fill_accept_s) begin
                valid_r[victim_s][set_idx_s] <= 1'b0;
            end
            if (state_r == ST_COMMIT) begin
                valid_r[victim_r][fill_set_r] <= 1'b1;
                tag_r[victim_r][fill_set_r]   <= fill_tag_r;
            end
        end
    end
endmodule

// File: tb/tb_assoc_way_array.sv
// Self-checking bench for assoc_way_array: a directed vector table, hand-written
// fill/reset sequences, then random traffic against a timestamp-based reference model.
module tb_assoc_way_array;
    localparam int WAYS   = 2;
    localparam int SETS   = 64;
    localparam int WORDS  = 8;
    localparam int DATA_W = 16;
    localparam int TAG_W  = 7;
`ifdef ASSOC_WAY_ARRAY_LRU_EN
    localparam bit LRU = 1'b1;
`else
    localparam bit LRU = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [SETS-1:0]   set_enable;
    logic [WORDS-1:0]  word_enable;
    logic [TAG_W-1:0]  tag_in;
    logic              rd_en, wr_en;
    logic [DATA_W-1:0] data_in;
    logic              hit;
    logic [WAYS-1:0]   hit_way;
    logic [DATA_W-1:0] data_out;
    logic              fill_start, fill_valid;
    logic [DATA_W-1:0] fill_data;
    logic              fill_ready, busy, fill_done;

    assoc_way_array #(.WAYS(WAYS), .SETS(SETS), .WORDS(WORDS), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .set_enable(set_enable), .word_enable(word_enable),
        .tag_in(tag_in), .rd_en(rd_en), .wr_en(wr_en), .data_in(data_in),
        .hit(hit), .hit_way(hit_way), .data_out(data_out),
        .fill_start(fill_start), .fill_valid(fill_valid), .fill_data(fill_data),
        .fill_ready(fill_ready), .busy(busy), .fill_done(fill_done)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // ---------------- reference model ----------------
    // Replacement is modelled with last-use timestamps: LRU = smallest stamp.
    bit                m_valid [WAYS][SETS];
    logic [TAG_W-1:0]  m_tag   [WAYS][SETS];
    logic [DATA_W-1:0] m_data  [WAYS][SETS][WORDS];
    int                m_stamp [WAYS][SETS];
    int                m_time, m_ptr, m_phase, m_beats, m_set, m_victim;
    logic [TAG_W-1:0]  m_ftag;

    task automatic model_reset();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) begin
                m_valid[w][s] = 1'b0;
                m_tag[w][s]   = '0;
                m_stamp[w][s] = w;
                for (int d = 0; d < WORDS; d++) m_data[w][s][d] = '0;
            end
        m_time = WAYS; m_ptr = 0; m_phase = 0; m_beats = 0; m_set = 0; m_victim = 0; m_ftag = '0;
    endtask

    function automatic int lowest_set();
        for (int i = 0; i < SETS; i++) if (set_enable[i]) return i;
        return -1;
    endfunction

    function automatic int lowest_word();
        for (int i = 0; i < WORDS; i++) if (word_enable[i]) return i;
        return 0;
    endfunction

    function automatic int first_hit(input int s);
        if (s < 0) return -1;
        for (int w = 0; w < WAYS; w++) if (m_valid[w][s] && m_tag[w][s] == tag_in) return w;
        return -1;
    endfunction

    function automatic int oldest(input int s);
        int best = 0;
        for (int w = 1; w < WAYS; w++) if (m_stamp[w][s] < m_stamp[best][s]) best = w;
        return best;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int s, wd, hw, v;
        if (rst) begin
            model_reset();
            return;
        end
        s  = lowest_set();
        wd = lowest_word();
        hw = first_hit(s);
        if (m_phase == 0) begin
            v = -1;
            if (fill_start && s >= 0) begin
                for (int w = 0; w < WAYS; w++) if (!m_valid[w][s] && v < 0) v = w;
                if (v < 0) v = LRU ? oldest(s) : m_ptr;
            end
            if (wr_en && hw >= 0) m_data[hw][s][wd] = data_in;
            if ((rd_en || wr_en) && hw >= 0) begin
                m_stamp[hw][s] = m_time;
                m_time++;
            end
            if (v >= 0) begin
                m_valid[v][s] = 1'b0;
                m_set = s; m_ftag = tag_in; m_victim = v; m_beats = 0; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (fill_valid) begin
                m_data[m_victim][m_set][m_beats] = fill_data;
                m_beats++;
                if (m_beats == WORDS) m_phase = 2;
            end
        end else begin
            m_valid[m_victim][m_set] = 1'b1;
            m_tag[m_victim][m_set]   = m_ftag;
            m_stamp[m_victim][m_set] = m_time;
            m_time++;
            m_ptr   = (m_ptr + 1) % WAYS;
            m_phase = 0;
        end
    endtask

    task automatic check_model(input string tagname);
        int s, hw;
        logic [WAYS-1:0] mask;
        s = lowest_set();
        hw = first_hit(s);
        mask = '0;
        if (s >= 0)
            for (int w = 0; w < WAYS; w++) mask[w] = m_valid[w][s] && (m_tag[w][s] == tag_in);
        check({tagname, " hit"}, 32'(hit), 32'(hw >= 0));
        check({tagname, " hit_way"}, 32'(hit_way), 32'(mask));
        check({tagname, " data_out"}, 32'(data_out), (hw >= 0) ? 32'(m_data[hw][s][lowest_word()]) : 32'h0);
        check({tagname, " busy"}, 32'(busy), 32'(m_phase != 0));
        check({tagname, " fill_ready"}, 32'(fill_ready), 32'(m_phase == 1));
        check({tagname, " fill_done"}, 32'(fill_done), 32'(m_phase == 2));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input int wd, input logic [TAG_W-1:0] t, input bit rd, input bit wr,
                         input logic [DATA_W-1:0] din, input bit fs, input bit fv, input logic [DATA_W-1:0] fd);
        set_enable = '0;
        if (s >= 0) set_enable[s] = 1'b1;
        word_enable = '0;
        word_enable[wd] = 1'b1;
        tag_in = t; rd_en = rd; wr_en = wr; data_in = din;
        fill_start = fs; fill_valid = fv; fill_data = fd;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int                set_i;
        int                word_i;
        logic [TAG_W-1:0]  tag_i;
        bit                rd_i, wr_i;
        logic [DATA_W-1:0] din_i;
        bit                fs_i, fv_i;
        logic [DATA_W-1:0] fd_i;
        bit                e_hit;
        logic [WAYS-1:0]   e_way;
        logic [DATA_W-1:0] e_data;
        bit                e_busy, e_ready, e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int s, input int wd, input logic [TAG_W-1:0] t, input bit rd, input bit wr,
                           input logic [DATA_W-1:0] din, input bit fs, input bit fv, input logic [DATA_W-1:0] fd,
                           input bit eh, input logic [WAYS-1:0] ew, input logic [DATA_W-1:0] ed,
                           input bit eb, input bit er, input bit edn);
        vec_t v;
        v.set_i = s; v.word_i = wd; v.tag_i = t; v.rd_i = rd; v.wr_i = wr; v.din_i = din;
        v.fs_i = fs; v.fv_i = fv; v.fd_i = fd;
        v.e_hit = eh; v.e_way = ew; v.e_data = ed; v.e_busy = eb; v.e_ready = er; v.e_done = edn;
        vecs.push_back(v);
    endtask

    logic [WAYS-1:0] victim_mask;
    int              rs, rr;

    initial begin
        drive(0, 0, 7'h00, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;

        // Lookup before any fill, then a first line into set 5.
        add_vec(5, 3, 7'h12, 1, 0, 16'h0, 0, 0, 16'h0, 0, 2'b00, 16'h0000, 0, 0, 0);
        add_vec(5, 3, 7'h12, 0, 0, 16'h0, 1, 0, 16'h0, 0, 2'b00, 16'h0000, 0, 0, 0);
        for (int i = 0; i < WORDS; i++)
            add_vec(5, 3, 7'h12, 0, 0, 16'h0, 0, 1, 16'(16'h1000 + i), 0, 2'b00, 16'h0000, 1, 1, 0);
        add_vec(5, 3, 7'h12, 0, 0, 16'h0, 0, 0, 16'h0, 0, 2'b00, 16'h0000, 1, 0, 1);
        // No set selected: write and fill start must both be ignored.
        add_vec(-1, 3, 7'h12, 0, 1, 16'hDEAD, 1, 0, 16'h0, 0, 2'b00, 16'h0000, 0, 0, 0);
        add_vec(5, 3, 7'h12, 1, 0, 16'h0, 0, 0, 16'h0, 1, 2'b01, 16'h1003, 0, 0, 0);
        // Hit write, then a miss write that must not land anywhere.
        add_vec(5, 7, 7'h12, 0, 1, 16'hBEEF, 0, 0, 16'h0, 1, 2'b01, 16'h1007, 0, 0, 0);
        add_vec(5, 7, 7'h12, 0, 0, 16'h0, 0, 0, 16'h0, 1, 2'b01, 16'hBEEF, 0, 0, 0);
        add_vec(5, 7, 7'h7F, 0, 1, 16'h5555, 0, 0, 16'h0, 0, 2'b00, 16'h0000, 0, 0, 0);
        add_vec(5, 7, 7'h12, 0, 0, 16'h0, 0, 0, 16'h0, 1, 2'b01, 16'hBEEF, 0, 0, 0);
        // Second line goes to the free way 1; lookups to way 0 stay served meanwhile.
        add_vec(5, 0, 7'h13, 0, 0, 16'h0, 1, 0, 16'h0, 0, 2'b00, 16'h0000, 0, 0, 0);
        for (int i = 0; i < WORDS; i++)
            add_vec(5, 0, 7'h12, 0, 0, 16'h0, 0, 1, 16'(16'h2000 + i), 1, 2'b01, 16'h1000, 1, 1, 0);
        add_vec(5, 0, 7'h12, 0, 0, 16'h0, 0, 0, 16'h0, 1, 2'b01, 16'h1000, 1, 0, 1);
        add_vec(5, 1, 7'h12, 1, 0, 16'h0, 0, 0, 16'h0, 1, 2'b01, 16'h1001, 0, 0, 0);
        add_vec(5, 2, 7'h13, 0, 0, 16'h0, 0, 0, 16'h0, 1, 2'b10, 16'h2002, 0, 0, 0);
        // Third line into a full set: the victim depends on the replacement policy.
        add_vec(5, 2, 7'h14, 0, 0, 16'h0, 1, 0, 16'h0, 0, 2'b00, 16'h0000, 0, 0, 0);
        add_vec(5, 0, 7'h12, 0, 0, 16'h0, 0, 0, 16'h0, LRU, LRU ? 2'b01 : 2'b00, LRU ? 16'h1000 : 16'h0000, 1, 1, 0);
        add_vec(5, 2, 7'h13, 0, 0, 16'h0, 0, 0, 16'h0, !LRU, LRU ? 2'b00 : 2'b10, LRU ? 16'h0000 : 16'h2002, 1, 1, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].set_i, vecs[i].word_i, vecs[i].tag_i, vecs[i].rd_i, vecs[i].wr_i, vecs[i].din_i,
                  vecs[i].fs_i, vecs[i].fv_i, vecs[i].fd_i);
            #1;
            check($sformatf("vec%0d hit", i), 32'(hit), 32'(vecs[i].e_hit));
            check($sformatf("vec%0d hit_way", i), 32'(hit_way), 32'(vecs[i].e_way));
            check($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].e_data));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("vec%0d fill_ready", i), 32'(fill_ready), 32'(vecs[i].e_ready));
            check($sformatf("vec%0d fill_done", i), 32'(fill_done), 32'(vecs[i].e_done));
            cycle();
        end

        // Finish the tag 0x14 fill with two-cycle gaps and a stray fill_start in each first gap.
        for (int b = 0; b < WORDS; b++) begin
            drive(5, b, 7'h14, 0, 0, 16'h0, 0, 1, 16'(16'h3000 + b));
            #1;
            check($sformatf("gap beat%0d fill_ready", b), 32'(fill_ready), 32'h1);
            check($sformatf("gap beat%0d fill_done", b), 32'(fill_done), 32'h0);
            cycle();
            if (b < WORDS - 1) begin
                for (int g = 0; g < 2; g++) begin
                    drive(5, 0, 7'h15, 0, 0, 16'h0, (g == 0), 0, 16'hFFFF);
                    #1;
                    check($sformatf("gap%0d.%0d fill_ready", b, g), 32'(fill_ready), 32'h1);
                    check($sformatf("gap%0d.%0d fill_done", b, g), 32'(fill_done), 32'h0);
                    cycle();
                end
            end
        end
        drive(5, 0, 7'h14, 0, 0, 16'h0, 0, 0, 16'h0);
        #1;
        check("gap commit fill_done", 32'(fill_done), 32'h1);
        cycle();
        check("gap after busy", 32'(busy), 32'h0);
        check("gap after fill_done", 32'(fill_done), 32'h0);
        victim_mask = LRU ? 2'b10 : 2'b01;
        for (int wd = 0; wd < WORDS; wd++) begin
            drive(5, wd, 7'h14, 0, 0, 16'h0, 0, 0, 16'h0);
            #1;
            check($sformatf("line14 w%0d hit_way", wd), 32'(hit_way), 32'(victim_mask));
            check($sformatf("line14 w%0d data", wd), 32'(data_out), 32'(16'h3000 + wd));
        end
        drive(5, 0, 7'h15, 0, 0, 16'h0, 0, 0, 16'h0);
        #1;
        check("stray start tag15 hit", 32'(hit), 32'h0);

        // Reset three beats into a fill: no commit, everything cleared.
        drive(5, 0, 7'h16, 0, 0, 16'h0, 1, 0, 16'h0);
        cycle();
        for (int b = 0; b < 3; b++) begin
            drive(5, 0, 7'h16, 0, 0, 16'h0, 0, 1, 16'(16'h4000 + b));
            cycle();
        end
        drive(5, 0, 7'h16, 0, 0, 16'h0, 0, 1, 16'h4003);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive(5, 0, 7'h12, 0, 0, 16'h0, 0, 0, 16'h0);
        #1;
        check("rst busy", 32'(busy), 32'h0);
        check("rst fill_ready", 32'(fill_ready), 32'h0);
        check("rst fill_done", 32'(fill_done), 32'h0);
        for (int t = 0; t < 5; t++) begin
            tag_in = 7'(7'h12 + t);
            #1;
            check($sformatf("rst tag%0h hit_way", tag_in), 32'(hit_way), 32'h0);
            check($sformatf("rst tag%0h data", tag_in), 32'(data_out), 32'h0);
        end
        cycle();
        check("rst no late commit", 32'(fill_done), 32'h0);

        // Random traffic over a few sets and tags against the reference model.
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            rs = $urandom_range(0, 3);
            rr = $urandom_range(0, 9);
            set_enable = '0;
            if (rr != 0) set_enable[rs] = 1'b1;
            if (rr == 9) set_enable[rs + 2] = 1'b1;
            word_enable = '0;
            if ($urandom_range(0, 7) != 0) word_enable[$urandom_range(0, WORDS - 1)] = 1'b1;
            tag_in     = 7'($urandom_range(0, 3));
            rd_en      = ($urandom_range(0, 1) == 1);
            wr_en      = ($urandom_range(0, 3) == 0);
            data_in    = 16'($urandom);
            fill_start = ($urandom_range(0, 9) == 0);
            fill_valid = ($urandom_range(0, 1) == 1);
            fill_data  = 16'($urandom);
            #1;
            check_model($sformatf("rnd%0d", c));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
